// File: rtl/point_mul_scheduler.sv
// point_mul_scheduler
//   Shares NUM_UNITS point_mul engines between a stream of scalar-multiply
//   jobs (P, k, tag). Jobs are dispatched to the lowest free slot. Results
//   return through a single output register in completion order, and a
//   round-robin choice is made when several slots finish together.
//
// Ports
//   clk, Reset              clock, synchronous active-high reset
//   in_valid/in_ready       job handshake; in_P, in_k, in_tag carry the job
//   out_valid/out_ready     result handshake; out_R, out_tag, out_inf
//   eng_reset[i]            start pulse for engine i
//   eng_P/eng_k             per-engine operands, held for the whole job
//   eng_done/eng_R          per-engine completion flag and result
//   busy_count              number of slots not IDLE
//
// Slot states
//   state   | meaning
//   S_IDLE  | free, may accept a job
//   S_START | engine start pulse is high this cycle
//   S_RUN   | engine computing, waiting for eng_done
//   S_HOLD  | result ready, waiting for the output register
module point_mul_scheduler #(
  parameter  int NUM_UNITS = 4,
  parameter  int TAG_W     = 8,
  parameter  int POINT_W   = 512,
  localparam int K_W       = 256,
  localparam int CNT_W     = $clog2(NUM_UNITS + 1),
  localparam int PTR_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [POINT_W-1:0]           in_P,
  input  logic [K_W-1:0]               in_k,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [POINT_W-1:0]           out_R,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_inf,
  output logic [NUM_UNITS-1:0]         eng_reset,
  output logic [NUM_UNITS*POINT_W-1:0] eng_P,
  output logic [NUM_UNITS*K_W-1:0]     eng_k,
  input  logic [NUM_UNITS-1:0]         eng_done,
  input  logic [NUM_UNITS*POINT_W-1:0] eng_R,
  output logic [CNT_W-1:0]             busy_count
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_HOLD} slot_state_t;

  slot_state_t          state_q [NUM_UNITS];
  slot_state_t          state_d [NUM_UNITS];
  logic [TAG_W-1:0]     tag_q   [NUM_UNITS];
  logic [TAG_W-1:0]     tag_d   [NUM_UNITS];
  logic [POINT_W-1:0]   p_q     [NUM_UNITS];
  logic [POINT_W-1:0]   p_d     [NUM_UNITS];
  logic [K_W-1:0]       k_q     [NUM_UNITS];
  logic [K_W-1:0]       k_d     [NUM_UNITS];
  logic [NUM_UNITS-1:0] inf_q, inf_d;

  logic                 out_valid_q, out_valid_d;
  logic [POINT_W-1:0]   out_r_q, out_r_d;
  logic [TAG_W-1:0]     out_tag_q, out_tag_d;
  logic                 out_inf_q, out_inf_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_UNITS-1:0] idle_vec, hold_vec;
  logic [CNT_W-1:0]     busy_cnt;
  logic                 sel_found, accept;
  logic [PTR_W-1:0]     sel_idx;
  logic                 win_found, load_out;
  logic [PTR_W-1:0]     win_idx;
  logic [TAG_W-1:0]     win_tag;
  logic                 win_inf;
  logic [POINT_W-1:0]   win_r;

  always_comb begin
    idle_vec  = '0;
    hold_vec  = '0;
    busy_cnt  = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      idle_vec[i] = (state_q[i] == S_IDLE);
      hold_vec[i] = (state_q[i] == S_HOLD);
      if (state_q[i] != S_IDLE) busy_cnt = busy_cnt + CNT_W'(1);
      if (!sel_found && idle_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(i);
      end
    end
  end

  assign in_ready = |idle_vec;
  assign accept   = in_valid & in_ready;

  // Round-robin: first look above rr_ptr, then wrap to 0..rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_tag   = '0;
    win_inf   = 1'b0;
    win_r     = '0;
    for (int j = 0; j < NUM_UNITS; j++) begin
      if (!win_found && hold_vec[j] && (j > int'(rr_ptr_q))) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(j);
        win_tag   = tag_q[j];
        win_inf   = inf_q[j];
        win_r     = inf_q[j] ? '0 : eng_R[j*POINT_W +: POINT_W];
      end
    end
    for (int j = 0; j < NUM_UNITS; j++) begin
      if (!win_found && hold_vec[j] && (j <= int'(rr_ptr_q))) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(j);
        win_tag   = tag_q[j];
        win_inf   = inf_q[j];
        win_r     = inf_q[j] ? '0 : eng_R[j*POINT_W +: POINT_W];
      end
    end
  end

  assign load_out = (!out_valid_q || out_ready) && win_found;

  always_comb begin
    inf_d = inf_q;
    for (int i = 0; i < NUM_UNITS; i++) begin
      state_d[i] = state_q[i];
      tag_d[i]   = tag_q[i];
      p_d[i]     = p_q[i];
      k_d[i]     = k_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (accept && (sel_idx == PTR_W'(i))) begin
            tag_d[i] = in_tag;
            if (in_k == '0) begin
              // k==0 gives the point at infinity; no engine needed.
              state_d[i] = S_HOLD;
              inf_d[i]   = 1'b1;
            end else begin
              state_d[i] = S_START;
              inf_d[i]   = 1'b0;
              p_d[i]     = in_P;
              k_d[i]     = in_k;
            end
          end
        end
        S_START: state_d[i] = S_RUN;
        S_RUN:   if (eng_done[i]) state_d[i] = S_HOLD;
        S_HOLD:  if (load_out && (win_idx == PTR_W'(i))) state_d[i] = S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_tag_d   = out_tag_q;
    out_inf_d   = out_inf_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_out) begin
      out_valid_d = 1'b1;
      out_r_d     = win_r;
      out_tag_d   = win_tag;
      out_inf_d   = win_inf;
      rr_ptr_d    = win_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        state_q[i] <= S_IDLE;
        tag_q[i]   <= '0;
        p_q[i]     <= '0;
        k_q[i]     <= '0;
      end
      inf_q       <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_tag_q   <= '0;
      out_inf_q   <= 1'b0;
      rr_ptr_q    <= PTR_W'(NUM_UNITS - 1);
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        state_q[i] <= state_d[i];
        tag_q[i]   <= tag_d[i];
        p_q[i]     <= p_d[i];
        k_q[i]     <= k_d[i];
      end
      inf_q       <= inf_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_tag_q   <= out_tag_d;
      out_inf_q   <= out_inf_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_eng
    assign eng_reset[g]                 = (state_q[g] == S_START);
    assign eng_P[g*POINT_W +: POINT_W]  = p_q[g];
    assign eng_k[g*K_W +: K_W]          = k_q[g];
  end

  assign out_valid  = out_valid_q;
  assign out_R      = out_r_q;
  assign out_tag    = out_tag_q;
  assign out_inf    = out_inf_q;
  assign busy_count = busy_cnt;

endmodule

// File: doc/point_mul_scheduler.md
# point_mul_scheduler

Job scheduler that shares a pool of `NUM_UNITS` `point_mul` engines between a stream of scalar-multiplication jobs (P, k, tag). It accepts jobs over a valid/ready input, dispatches each one to a free engine by pulsing that engine's `Reset`, and watches the engine's `Done`. Completed results return over a valid/ready output in completion order, chosen round-robin when several finish together. It sits between the MSM job front end and the engine array; tags let the downstream bucket accumulator match results to jobs.

## Interface
- `NUM_UNITS`, 4, number of attached `point_mul` engines (≥1)
- `TAG_W`, 8, width of the job tag carried with each job
- `clk` in 1: clock
- `Reset` in 1: synchronous, active-high reset
- `in_valid` in 1: job offered
- `in_ready` out 1: a slot is IDLE (combinational from slot state only)
- `in_P` in curve_point_t: base point
- `in_k` in 256: scalar
- `in_tag` in TAG_W: job tag
- `out_valid` out 1: result register full
- `out_ready` in 1: consumer accepts
- `out_R` out curve_point_t: k·P
- `out_tag` out TAG_W: tag of the result
- `out_inf` out 1: result is the point at infinity (k==0); `out_R` is '0
- `eng_reset` out NUM_UNITS: per-engine start pulse, driving engine `Reset`
- `eng_P` out NUM_UNITS × curve_point_t: per-engine P, held for the whole job
- `eng_k` out NUM_UNITS × 256: per-engine k, held for the whole job
- `eng_done` in NUM_UNITS: engine `Done`
- `eng_R` in NUM_UNITS × curve_point_t: engine `R`, stable while `Done`=1
- `busy_count` out $clog2(NUM_UNITS+1): number of slots not IDLE

## Operation
- Each slot i has a state machine with states IDLE, START, RUN and HOLD, plus registers tag_i, inf_i, eng_P[i] and eng_k[i].
  - IDLE -> START when a job is accepted into slot i with k≠0. Load eng_P, eng_k and tag. eng_reset[i] is registered and is high only while in START.
  - IDLE -> HOLD when a job is accepted with k==0. Set inf_i=1. The engine is never pulsed.
  - START -> RUN unconditionally after one cycle.
  - RUN -> HOLD on the first cycle in RUN where eng_done[i]=1.
  - HOLD -> IDLE on the edge where slot i's result is loaded into the output register.
- Dispatch: an accept happens when in_valid & in_ready. The job goes to the lowest-index IDLE slot.
- A slot leaving HOLD on an edge is not IDLE during that cycle, so it cannot accept a job on that edge. It becomes eligible next cycle.
- Output register: it loads when !out_valid | out_ready and at least one slot is in HOLD.
  - The winner is chosen round-robin, searching from rr_ptr+1 upward and wrapping. rr_ptr is then set to the winner.
  - out_R = inf ? '0 : eng_R[winner]. out_tag and out_inf come from the slot registers.
  - If out_valid & out_ready and no slot is in HOLD, out_valid drops.
- Output contents are stable while out_valid & !out_ready.
- busy_count counts slots in START, RUN or HOLD.
- Reset values:
  - All slots IDLE; eng_reset=0; eng_P, eng_k and tags = 0.
  - out_valid=0, out_R=0, out_tag=0, out_inf=0, busy_count=0.
  - rr_ptr=NUM_UNITS-1, so slot 0 has first priority.
- Reset mid-operation: all jobs in flight are dropped and no result is emitted for them. Engines may keep computing; the next START pulse reinitialises them. Reset has priority over every other event.
- eng_done is ignored in IDLE, START and HOLD.

## Timing
- Accept at cycle t with k≠0:
  - eng_reset high in t+1.
  - RUN from t+2; eng_done is sampled from t+2.
- k==1: the engine raises Done at the end of t+1.
  - The slot is in HOLD at t+3.
  - out_valid is high at t+4 if the output is free and the slot wins. This is the minimum latency.
- General k: if eng_done first rises in cycle d ≥ t+2, the slot is in HOLD at d+1 and out_valid is high at d+2 at the earliest.
- k==0: the slot is in HOLD at t+1 and out_valid is high at t+2 at the earliest.
- Throughput is one accept per cycle while slots are free, and one result per cycle with out_ready held at 1.
- in_ready drops the cycle after the last IDLE slot is taken.

## Test plan
- Single job, P=G, k=1, tag=5, out_ready=1, accepted at t:
  - eng_reset[0] high only at t+1.
  - out_valid at t+4 with out_R=G, out_tag=5, out_inf=0.
  - busy_count=0 at t+5.
- Job k=0, tag=7:
  - eng_reset stays 0.
  - out_valid at t+2 with out_inf=1, out_R=0, out_tag=7.
- Four back-to-back jobs k=2,3,4,5 with tags 0–3:
  - Slots 0–3 are filled in that order; in_ready=0 and busy_count=4.
  - A fifth job waits until a slot frees, then takes that slot.
  - Each result equals k·G with its matching tag.
- Backpressure: four jobs complete while out_ready=0 for 50 cycles.
  - out_valid=1 and outputs are stable; in_ready=0.
  - On release, tags emerge round-robin 0,1,2,3, one per cycle.
- Stubbed engines raise eng_done on all slots in the same cycle, repeated over three rounds:
  - Grant order rotates, starting each round after the previous winner.
  - No slot is starved.
- Reset asserted while two jobs are in RUN and out_valid=1:
  - The next cycle has out_valid=0, in_ready=1, busy_count=0 and eng_reset=0.
  - A following k=3 job returns 3·G and no stale tag ever appears.
